// File: rtl/pll_reconfig_seq.sv
// Buffers a batch of PLL register writes and replays it on the Avalon-MM reconfig port:
// mode write, batch, start write, then wait for lock. Optional lock timeout: PLL_RECONFIG_TIMEOUT_EN.
module pll_reconfig_seq #(
  parameter int AW             = 6,
  parameter int DW             = 32,
  parameter int DEPTH          = 16,
  parameter int MODE_ADDR      = 0,
  parameter int START_ADDR     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     commit,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [AW-1:0]            mgmt_address,
  output logic [DW-1:0]            mgmt_writedata,
  output logic                     mgmt_write,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [AW-1:0] MODE_A  = MODE_ADDR[AW-1:0];
  localparam logic [AW-1:0] START_A = START_ADDR[AW-1:0];

  typedef enum logic [2:0] {IDLE, MODE, DRAIN, START, LOCK, FIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, accept, pop, clear;
  logic          lock_ok, timeout;

  assign full     = (count == LW'(DEPTH));
  assign wr_ready = (state == IDLE) && !full;
  assign accept   = wr_valid && wr_ready;
  assign clear    = (state == IDLE) && flush;
  assign pop      = (state == DRAIN) && !mgmt_waitrequest;
  assign lock_ok  = !mgmt_waitrequest && pll_locked;
  assign level    = count;
  assign busy     = (state == MODE) || (state == DRAIN) || (state == START) || (state == LOCK);
  assign done     = (state == FIN);

  // Flush takes priority over a same-cycle accept so the buffer always ends up empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(accept) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (commit) begin
          if (flush)                                 state_nxt = FIN;
          else if ((count != '0) || accept)          state_nxt = MODE;
          else                                       state_nxt = FIN;
        end
      end
      MODE:  if (!mgmt_waitrequest) state_nxt = DRAIN;
      // The last entry is recognised by the count before its pop.
      DRAIN: if (!mgmt_waitrequest && (count == LW'(1))) state_nxt = START;
      START: if (!mgmt_waitrequest) state_nxt = LOCK;
      LOCK: begin
        if (lock_ok)      state_nxt = FIN;
        else if (timeout) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    case (state)
      MODE: begin
        mgmt_write   = 1'b1;
        mgmt_address = MODE_A;
      end
      DRAIN: begin
        mgmt_write     = 1'b1;
        mgmt_address   = addr_mem[rd_ptr];
        mgmt_writedata = data_mem[rd_ptr];
      end
      START: begin
        mgmt_write   = 1'b1;
        mgmt_address = START_A;
      end
      default: ;
    endcase
  end

`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] lock_cnt;
  logic          error_q;

  // The counter reads i in the i-th LOCK cycle, so FIN lands exactly TIMEOUT_CYCLES after LOCK entry.
  assign timeout = (state == LOCK) && (lock_cnt == T_LAST);
  assign error   = error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if ((state == START) && !mgmt_waitrequest) lock_cnt <= '0;
      else if (state == LOCK)                    lock_cnt <= lock_cnt + 1'b1;
      if ((state == IDLE) && commit)             error_q <= 1'b0;
      else if (timeout && !lock_ok)              error_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Randomised scoreboard bench for pll_reconfig_seq: a queue model of the batch predicts
// the management write stream, which a separate monitor compares write by write.
module tb_pll_reconfig_seq;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TMO   = 100;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              commit;
  logic              flush;
  logic [$clog2(DEPTH):0] level;
  logic              busy;
  logic              done;
  logic              error;
  logic [AW-1:0]     mgmt_address;
  logic [DW-1:0]     mgmt_writedata;
  logic              mgmt_write;
  logic              mgmt_waitrequest;
  logic              pll_locked;

  always #5 clk = ~clk;

  pll_reconfig_seq #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .MODE_ADDR(0), .START_ADDR(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .flush(flush), .level(level),
    .busy(busy), .done(done), .error(error),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t model_fifo[$];
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_done = 0;
  int  seen_done = 0;
  bit  auto_wait = 1'b0;
  bit  auto_lock = 1'b0;
  int  stall_pct = 0;
  int  lock_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin : wait_driver
    forever begin
      @(posedge clk); #1;
      if (auto_wait) mgmt_waitrequest = ($urandom_range(99) < stall_pct);
    end
  end

  initial begin : lock_driver
    forever begin
      @(posedge clk); #1;
      if (auto_lock) pll_locked = ($urandom_range(99) < lock_pct);
    end
  end

  // Completed writes are popped from the expected stream; a stalled write must hold steady.
  initial begin : monitor
    bit            prev_stall;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;
    wr_t           e;
    prev_stall = 1'b0;
    prev_a = '0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall)
        check("stall_hold", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, prev_a, prev_d});
      if (mgmt_write && !mgmt_waitrequest) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write actual=%0h/%0h required=none", mgmt_address, mgmt_writedata);
        end else begin
          e = exp_q.pop_front();
          checks--;
          check("mgmt_xact", {mgmt_address, mgmt_writedata}, e);
        end
      end
      prev_stall = mgmt_write && mgmt_waitrequest;
      prev_a = mgmt_address;
      prev_d = mgmt_writedata;
      if (done) seen_done++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit exp_ready;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    exp_ready = (model_fifo.size() < DEPTH);
    @(negedge clk);
    check("wr_ready", wr_ready, exp_ready);
    if (exp_ready) model_fifo.push_back('{a: a, d: d});
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("level_after_push", level, model_fifo.size());
  endtask

  task automatic do_commit(input bit with_flush, input bit with_entry,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    commit = 1'b1;
    flush  = with_flush;
    if (with_entry) begin
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
    end
    if (with_flush) begin
      model_fifo.delete();
    end else begin
      if (with_entry && model_fifo.size() < DEPTH) model_fifo.push_back('{a: a, d: d});
      if (model_fifo.size() > 0) begin
        exp_q.push_back('{a: 6'd0, d: 32'd0});
        foreach (model_fifo[i]) exp_q.push_back(model_fifo[i]);
        exp_q.push_back('{a: 6'd2, d: 32'd0});
      end
      model_fifo.delete();
    end
    exp_done++;
    @(posedge clk); #1;
    commit   = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    model_fifo.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    check("level_after_flush", level, 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 4000);
    check({name, "_done_seen"}, done, 1'b1);
    @(negedge clk);
    check({name, "_done_single"}, done, 1'b0);
    check({name, "_idle_busy"}, busy, 1'b0);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_level"}, level, model_fifo.size());
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    reset_n = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit = 1'b0;
    flush = 1'b0;
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_busy_done_error", {busy, done, error}, 3'b000);
    check("rst_mgmt", {mgmt_write, mgmt_address, mgmt_writedata}, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;

    // Zero-stall batch of three: five consecutive writes, then LOCK, then FIN.
    push_entry(6'h05, 32'h11);
    push_entry(6'h06, 32'h22);
    push_entry(6'h07, 32'h33);
    do_commit(1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("t1_write_c%0d", i), mgmt_write, (i <= 5));
      check($sformatf("t1_done_c%0d", i), done, (i == 7));
      if (i == 1) check("t1_busy_n1", busy, 1'b1);
    end
    @(posedge clk); #1;
    check("t1_level", level, 0);
    check("t1_drained", exp_q.size(), 0);

    // Same batch with entry 06 stalled for four cycles.
    push_entry(6'h05, 32'h11);
    push_entry(6'h06, 32'h22);
    push_entry(6'h07, 32'h33);
    do_commit(1'b0, 1'b0, '0, '0);
    repeat (2) begin @(posedge clk); #1; end
    mgmt_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mgmt_waitrequest = 1'b0;
      @(negedge clk);
      check($sformatf("t2_hold_c%0d", i), {mgmt_write, mgmt_address, mgmt_writedata},
            {1'b1, 6'h06, 32'h22});
      @(posedge clk); #1;
    end
    wait_done("t2");

    // Fill to DEPTH, offer one more, then replay under random stalls.
    for (int i = 0; i <= DEPTH; i++) push_entry(AW'($urandom), $urandom);
    check("t3_level_full", level, DEPTH);
    auto_wait = 1'b1;
    stall_pct = 30;
    do_commit(1'b0, 1'b0, '0, '0);
    wait_done("t3");
    auto_wait = 1'b0;
    mgmt_waitrequest = 1'b0;

    // Empty commit goes straight to FIN.
    do_commit(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t4_done", {done, busy, mgmt_write}, 3'b100);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_done_once", done, 1'b0);
    @(posedge clk); #1;

    // Reset while the second of three entries is on the bus.
    push_entry(6'h11, 32'hA1);
    push_entry(6'h12, 32'hA2);
    push_entry(6'h13, 32'hA3);
    do_commit(1'b0, 1'b0, '0, '0);
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("t5_async_mgmt_write", mgmt_write, 1'b0);
    check("t5_async_level_busy", {level, busy}, '0);
    exp_q.delete();
    model_fifo.delete();
    exp_done--;
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_entry(6'h21, 32'hBEEF);
    do_commit(1'b0, 1'b0, '0, '0);
    wait_done("t5");

`ifdef PLL_RECONFIG_TIMEOUT_EN
    // Lock never arrives: LOCK is entered at N+4, so FIN and error appear at N+4+TMO.
    pll_locked = 1'b0;
    push_entry(6'h31, 32'h55);
    do_commit(1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 4 + TMO; i++) begin
      @(negedge clk);
      if (i == 3 + TMO) check("t6_no_early_done", done, 1'b0);
      if (i == 4 + TMO) check("t6_timeout", {done, error}, 2'b11);
      if (i < 4 + TMO) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    pll_locked = 1'b1;
    @(negedge clk);
    check("t6_error_sticky", error, 1'b1);
    @(posedge clk); #1;
    do_commit(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t6_error_cleared", {done, error}, 2'b10);
    @(posedge clk); #1;
`endif

    // Random batches, flushes and commit corner cases.
    auto_wait = 1'b1;
    auto_lock = 1'b1;
    stall_pct = 25;
    lock_pct = 70;
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(DEPTH + 2);
      for (int j = 0; j < n; j++) push_entry(AW'($urandom), $urandom);
      case ($urandom_range(9))
        0: do_flush();
        1: begin do_commit(1'b1, 1'b0, '0, '0); wait_done("rnd_flush_commit"); end
        2: begin do_commit(1'b0, 1'b1, AW'($urandom), $urandom); wait_done("rnd_commit_wr"); end
        default: begin do_commit(1'b0, 1'b0, '0, '0); wait_done("rnd_commit"); end
      endcase
    end

    auto_wait = 1'b0;
    auto_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifndef PLL_RECONFIG_TIMEOUT_EN
    check("error_tied_low", error, 1'b0);
`endif
    check("done_count", seen_done, exp_done);
    check("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
Parametrised PLL-reconfiguration sequencer; successor to the ad-hoc FIFO-pop/cfg_write loop in front of pll_cfg.
- Buffers a batch of (address, value) register writes from the core; each write enters through a valid/ready handshake.
- On commit, replays the batch onto the Avalon-MM management port of the PLL reconfig block. The sequence is: mode write, then the batch, then the start write, then a wait for lock.
- Sits in the CLK_50M domain between the clock-crossing FIFO and pll_cfg. It replaces the inline always_ff writer.

Parameters:
AW, 6, management address width
DW, 32, management data width
DEPTH, 16, batch buffer entries (power of 2, >=2)
MODE_ADDR, 0, mode register address (written with 0 = waitrequest mode)
START_ADDR, 2, start register address (written with 0)
TIMEOUT_CYCLES, 1000000, lock-wait limit (used only with the optional feature)

Ports:
clk  in  1  sequencer/management clock (CLK_50M)
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  batch entry offered
wr_ready  out  1  entry accepted when wr_valid & wr_ready
wr_addr  in  AW  register address of entry
wr_data  in  DW  register value of entry
commit  in  1  single-cycle pulse: replay buffered batch
flush  in  1  discard buffered entries (IDLE only)
level  out  $clog2(DEPTH)+1  entries currently buffered
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of sequence
error  out  1  sticky lock-timeout flag
mgmt_address  out  AW  Avalon-MM address
mgmt_writedata  out  DW  Avalon-MM write data
mgmt_write  out  1  Avalon-MM write request
mgmt_waitrequest  in  1  Avalon-MM stall
pll_locked  in  1  PLL lock (pre-synchronised)

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, FIFO empty, level=0.
  - busy=0, done=0, error=0.
  - mgmt_write=0, mgmt_address=0, mgmt_writedata=0.
- wr_ready = (state==IDLE) & ~full.
- Entry accept occurs on the clk edge where wr_valid & wr_ready. Entries are in FIFO order.
- Full: level==DEPTH → wr_ready=0; no overwrite.
- FSM states: IDLE, MODE, DRAIN, START, LOCK, FIN.
- IDLE:
  - commit with level>0 → MODE next cycle; busy=1 from that cycle.
  - commit with level==0 → FIN; no mgmt traffic.
  - commit and an accepted write in the same cycle → the entry is included in the batch.
  - commit and flush in the same cycle → flush wins; FIFO cleared; FIN.
  - commit clears error.
- Avalon write rule, applied in MODE, DRAIN and START:
  - mgmt_write=1 with address/data stable until the edge where mgmt_waitrequest=0.
  - That edge completes the write.
  - mgmt_write is never dropped while stalled.
- Per-state behaviour:
  - MODE: writes (MODE_ADDR, 0); on completion → DRAIN.
  - DRAIN: writes the FIFO head. On completion the head is popped, then:
    - if more entries remain, the next entry is presented the following cycle with mgmt_write held at 1 (back-to-back, no idle cycle when waitrequest=0);
    - if the popped entry was the last, → START.
  - START: writes (START_ADDR, 0); on completion → LOCK; mgmt_write=0.
  - LOCK: waits for mgmt_waitrequest=0 & pll_locked=1 sampled in the same cycle → FIN.
  - FIN: done=1 for exactly one cycle; busy=0; → IDLE.
- Latency:
  - commit at cycle N → mgmt_write=1 at N+1.
  - With zero stall, k entries complete at N+1..N+k+2 (mode + k entries + start).
- commit, flush and wr_valid are ignored while busy.
- reset_n assertion mid-sequence:
  - immediate return to IDLE; FIFO emptied; mgmt_write=0 asynchronously.
  - No partial-sequence recovery.
- level updates the cycle after accept/pop/flush.

Optional Feature:
PLL_RECONFIG_TIMEOUT_EN.
- Defined:
  - a counter of width $clog2(TIMEOUT_CYCLES+1) clears on LOCK entry and increments each cycle in LOCK.
  - Reaching TIMEOUT_CYCLES without the lock condition → error=1 (sticky until the next commit or reset) → FIN, which still pulses done.
- Undefined: no counter; LOCK waits indefinitely; error is tied to 0.

Test Plan:
1. Push 3 entries (05,0x11),(06,0x22),(07,0x33); commit with waitrequest=0, locked=1 → mgmt writes (00,0),(05,11),(06,22),(07,33),(02,0) on consecutive cycles; done pulses once; level=0.
2. Same batch; waitrequest=1 for 4 cycles during entry (06,22) → mgmt_write stays 1 with 06/0x22 stable for 5 cycles; no entry skipped or duplicated.
3. Push DEPTH=16 entries, then offer a 17th → wr_ready=0 at level=16; the 17th is not stored; commit replays exactly 16 entries.
4. Commit with empty FIFO → done pulses at N+1 (FIN); mgmt_write never asserted; busy stays 0.
5. Assert reset_n=0 during DRAIN after 1 of 3 entries → mgmt_write=0 immediately; level=0, busy=0; new commit with 1 entry gives a normal full sequence.
6. With PLL_RECONFIG_TIMEOUT_EN, TIMEOUT_CYCLES=100, locked held 0 → done and error=1 exactly 100 cycles after LOCK entry; next commit clears error.
